mips_dmem_ctrl: RTL and testbench
=================================

# mips_dmem_ctrl

Parametrised data-memory controller for the pipelined MIPS core, sitting between the datapath's memory stage (ALUOut/WriteData/MemWriteM) and the on-chip data RAM. It is the successor to the fixed single-cycle word memory. It adds:
- configurable wait states, with a Stall handshake back to the pipeline
- byte, halfword and word accesses, with sign or zero extension on loads
- misalignment detection
- a parametrised debug tap

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥4
- WAIT_STATES, 2, extra cycles per access; 0..15 (0 = single-cycle)
- TEST_W, 16, width of test_value; 1..32
- TEST_ADDR, 0, word index mirrored onto test_value

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-low
- A  in  32  byte address from the memory stage
- WD  in  32  store data, right-justified
- RE  in  1  load request
- WE  in  1  store request
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- Signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
- RD  out  32  load data, valid only in the completion cycle of a load
- Stall  out  1  freeze upstream pipeline stages; combinational
- Misaligned  out  1  access rejected for alignment; combinational
- test_value  out  TEST_W  mem[TEST_ADDR][TEST_W-1:0]

## Operation
- Requests:
  - Request: req = RE | WE.
  - If RE and WE are both high, the access is a store (WE wins).
- Word indexing:
  - Word index = A[log2(DEPTH_WORDS)+1 : 2].
  - Higher address bits are ignored; addresses wrap modulo DEPTH_WORDS*4.
- Byte lanes (little-endian, lane = A[1:0]):
  - Byte access uses lane A[1:0].
  - Half access uses lanes {A[1],0} and {A[1],1}.
  - Word access uses all four lanes.
- Stores: write only the selected lanes, taking WD[7:0] or WD[15:0] for sub-word sizes. The other lanes are preserved.
- Loads: extract the selected lanes, then sign- or zero-extend according to Signed.
- Misalignment:
  - Condition: half access with A[0]=1, or word access with A[1:0]≠0, while req=1.
  - Response: Misaligned=1, Stall=0, no write, RD=0, FSM stays in IDLE.
- FSM states: IDLE, WAIT. The wait counter cnt is 4 bits.
  - IDLE, aligned req, WAIT_STATES=0: access completes this cycle. Stall=0, store commits at the edge, RD is valid combinationally. Stay in IDLE.
  - IDLE, aligned req, WAIT_STATES>0: Stall=1; go to WAIT with cnt=1.
  - WAIT, req held, cnt<WAIT_STATES: Stall=1; cnt increments.
  - WAIT, req held, cnt==WAIT_STATES: completion cycle. Stall=0, store commits at the edge, RD is valid. Go to IDLE with cnt=0.
  - WAIT, req dropped (RE=WE=0): abort. No write, Stall=0, go to IDLE with cnt=0.
- Upstream stability: the pipeline must hold A, WD, RE, WE, Size and Signed stable while Stall=1. Inputs are sampled only in the completion cycle.
- RD is 0 in every cycle that is not a load completion.
- test_value is combinational from the array, so it reflects a store from the following cycle onward.

## Timing
- Reset (RST=0, asynchronous):
  - Clears every memory word to 0.
  - FSM goes to IDLE, cnt=0.
  - Outputs: RD=0, Stall=0, Misaligned=0, test_value=0. All hold while RST=0.
- Reset asserted mid-WAIT: the access is aborted and no write occurs.
- Release: first acceptance is on the first rising edge with RST=1.
- Access latency: WAIT_STATES+1 cycles from request presentation to completion. Stall is high for exactly the first WAIT_STATES of those cycles.
- Back-to-back: a new request may be presented in the cycle after completion. There is no idle bubble.
- Misaligned and Stall are never high in the same cycle.

## Test plan
- WAIT_STATES=0; store word 0xDEADBEEF at A=0x10, then load word at 0x10 → RD=0xDEADBEEF in the same cycle, Stall never high.
- WAIT_STATES=2; store word 0x12345678 at A=0x0 → Stall=1 for 2 cycles, write in cycle 3, test_value=0x5678 on the next cycle; load byte A=0x3 with Signed=0 → RD=0x00000012.
- Store byte 0x80 at A=0x5, then:
  - load byte Signed=1 → RD=0xFFFFFF80
  - load byte Signed=0 → RD=0x00000080
  - load half A=0x4 → RD=0xFFFF8000 (lane 0 is 0 after reset)
- Half store at A=0x7 and word load at A=0x2 → Misaligned=1, Stall=0, memory unchanged, RD=0.
- WAIT_STATES=3; drop WE after 1 stall cycle → FSM returns to IDLE, word unchanged. Separately, assert RST=0 mid-WAIT → all outputs 0 immediately and memory cleared.
- DEPTH_WORDS=256; store at A=0x400 → lands in word 0 (wrap), test_value updates.

Source files
------------

// File: rtl/mips_dmem_ctrl_if.sv
// Memory-stage bus between the MIPS datapath and the data-memory controller.
interface mips_dmem_ctrl_if;
    logic [31:0] A;
    logic [31:0] WD;
    logic        RE;
    logic        WE;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] RD;
    logic        Stall;
    logic        Misaligned;

    modport master (
        output A, WD, RE, WE, Size, Signed,
        input  RD, Stall, Misaligned
    );

    modport slave (
        input  A, WD, RE, WE, Size, Signed,
        output RD, Stall, Misaligned
    );
endinterface

// File: rtl/mips_dmem_ctrl.sv
// Data-memory controller: wait states with stall handshake, byte/half/word
// accesses with load extension, alignment checking and a debug tap word.
module mips_dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TEST_W      = 16,
    parameter int unsigned TEST_ADDR   = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    mips_dmem_ctrl_if.slave      bus,
    output logic [TEST_W-1:0]    test_value
);
    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [AW-1:0] TADDR = AW'(TEST_ADDR);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          req_c;
    logic          misalign_c;
    logic          misal_raw_c;
    logic [AW-1:0] idx_c;
    logic [1:0]    lane_c;
    logic [3:0]    be_c;
    logic [31:0]   wlanes_c;
    logic [31:0]   old_word_c;
    logic [31:0]   merged_c;
    logic [31:0]   shifted_c;
    logic [31:0]   load_c;
    logic          stall_c;
    logic          done_c;
    logic          wr_en_c;
    logic          unused_a;

    // Address bits above the array wrap and are deliberately ignored.
    assign unused_a = &{1'b0, bus.A[31:AW+2]};

    // Decode size/lane into byte enables, replicated store lanes and load data.
    always_comb begin
        req_c      = bus.RE | bus.WE;
        idx_c      = bus.A[AW+1:2];
        lane_c     = bus.A[1:0];
        old_word_c = mem_q[idx_c];
        be_c       = 4'hF;
        wlanes_c   = bus.WD;
        misal_raw_c = 1'b0;
        case (bus.Size)
            2'b00: begin
                be_c     = 4'b0001 << lane_c;
                wlanes_c = {4{bus.WD[7:0]}};
            end
            2'b01: begin
                be_c        = bus.A[1] ? 4'b1100 : 4'b0011;
                wlanes_c    = {2{bus.WD[15:0]}};
                misal_raw_c = bus.A[0];
            end
            default: begin
                be_c        = 4'hF;
                wlanes_c    = bus.WD;
                misal_raw_c = |bus.A[1:0];
            end
        endcase
        misalign_c = req_c & misal_raw_c;

        for (int i = 0; i < 4; i++) begin
            merged_c[8*i +: 8] = be_c[i] ? wlanes_c[8*i +: 8] : old_word_c[8*i +: 8];
        end

        // Aligned accesses start at lane*8, so one shift serves every size.
        shifted_c = old_word_c >> {lane_c, 3'b000};
        case (bus.Size)
            2'b00:   load_c = bus.Signed ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                         : {24'h0, shifted_c[7:0]};
            2'b01:   load_c = bus.Signed ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                         : {16'h0, shifted_c[15:0]};
            default: load_c = old_word_c;
        endcase
    end

    // Next-state logic for the wait-state sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_c && !misalign_c) begin
                    if (WAIT_STATES == 0) begin
                        done_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                // Dropped or (illegally) changed-to-misaligned request aborts.
                if (!req_c || misalign_c) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q < WS) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        wr_en_c = done_c & bus.WE;
    end

    // Sequencer state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array; cleared by reset, written only on store completion.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (wr_en_c) begin
            mem_q[idx_c] <= merged_c;
        end
    end

    // Handshake outputs are forced low while reset is asserted.
    assign bus.Stall      = RST & stall_c;
    assign bus.Misaligned = RST & misalign_c;
    assign bus.RD         = (RST && done_c && bus.RE && !bus.WE) ? load_c : 32'h0;
    assign test_value     = mem_q[TADDR][TEST_W-1:0];
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Directed bench for mips_dmem_ctrl with 0, 2 and 3 wait-state instances.
module tb_mips_dmem_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] wd;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    int          sel;

    logic [31:0] rd_o;
    logic        stall_o;
    logic        mis_o;
    logic [15:0] tv_o;
    logic [15:0] tv0, tv2, tv3;

    int checks;
    int errors;

    mips_dmem_ctrl_if bus0 ();
    mips_dmem_ctrl_if bus2 ();
    mips_dmem_ctrl_if bus3 ();

    mips_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(0), .TEST_W(16), .TEST_ADDR(0))
        u_ws0 (.CLK(clk), .RST(rst_n), .bus(bus0), .test_value(tv0));
    mips_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2), .TEST_W(16), .TEST_ADDR(0))
        u_ws2 (.CLK(clk), .RST(rst_n), .bus(bus2), .test_value(tv2));
    mips_dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(3), .TEST_W(16), .TEST_ADDR(0))
        u_ws3 (.CLK(clk), .RST(rst_n), .bus(bus3), .test_value(tv3));

    assign bus0.A = a;  assign bus0.WD = wd; assign bus0.Size = size; assign bus0.Signed = sgn;
    assign bus2.A = a;  assign bus2.WD = wd; assign bus2.Size = size; assign bus2.Signed = sgn;
    assign bus3.A = a;  assign bus3.WD = wd; assign bus3.Size = size; assign bus3.Signed = sgn;
    assign bus0.RE = re & (sel == 0); assign bus0.WE = we & (sel == 0);
    assign bus2.RE = re & (sel == 1); assign bus2.WE = we & (sel == 1);
    assign bus3.RE = re & (sel == 2); assign bus3.WE = we & (sel == 2);

    always_comb begin
        case (sel)
            0:       begin rd_o = bus0.RD; stall_o = bus0.Stall; mis_o = bus0.Misaligned; tv_o = tv0; end
            1:       begin rd_o = bus2.RD; stall_o = bus2.Stall; mis_o = bus2.Misaligned; tv_o = tv2; end
            default: begin rd_o = bus3.RD; stall_o = bus3.Stall; mis_o = bus3.Misaligned; tv_o = tv3; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request and hold it until Stall drops; returns completion-cycle values.
    task automatic access(input logic [31:0] ai, input logic [31:0] wdi, input logic rei,
                          input logic wei, input logic [1:0] szi, input logic sgi,
                          output logic [31:0] rdv, output int stalls, output logic misv);
        logic done;
        done   = 1'b0;
        stalls = 0;
        rdv    = 32'h0;
        misv   = 1'b0;
        @(negedge clk);
        a = ai; wd = wdi; re = rei; we = wei; size = szi; sgi = sgi; sgn = sgi;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall_o) begin
                rdv  = rd_o;
                misv = mis_o;
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout a=%h stalls=%0d required completion", ai, stalls);
        end
        @(posedge clk);
        #1;
        re = 1'b0;
        we = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1; re = 1'b1; we = 1'b0; a = 32'h0; size = 2'b10; sgn = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
        checks++; if (rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", rd_o); end
        checks++; if (tv_o !== 16'h0) begin errors++; $display("FAIL reset_tv got %h want 0", tv_o); end
        a = 32'h2;
        #1;
        checks++; if (mis_o !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", mis_o); end
        re = 1'b0; a = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ws0();
        logic [31:0] r; int st; logic m;
        sel = 0;
        access(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, r, st, m);
        checks++; if (st !== 0) begin errors++; $display("FAIL ws0_store_stall got %0d want 0", st); end
        access(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL ws0_load got %h want deadbeef", r); end
        checks++; if (st !== 0) begin errors++; $display("FAIL ws0_load_stall got %0d want 0", st); end
    endtask

    task automatic test_ws2();
        logic [31:0] r; int st; logic m;
        sel = 1;
        access(32'h0, 32'h12345678, 1'b0, 1'b1, 2'b10, 1'b0, r, st, m);
        checks++; if (st !== 2) begin errors++; $display("FAIL ws2_store_stall got %0d want 2", st); end
        checks++; if (tv_o !== 16'h5678) begin errors++; $display("FAIL ws2_tv got %h want 5678", tv_o); end
        access(32'h3, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, r, st, m);
        checks++; if (r !== 32'h00000012) begin errors++; $display("FAIL ws2_lb got %h want 00000012", r); end
        checks++; if (st !== 2) begin errors++; $display("FAIL ws2_load_stall got %0d want 2", st); end
    endtask

    task automatic test_subword();
        logic [31:0] r; int st; logic m;
        sel = 1;
        access(32'h5, 32'hFFFFFF80, 1'b0, 1'b1, 2'b00, 1'b0, r, st, m);
        access(32'h5, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, r, st, m);
        checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h want ffffff80", r); end
        access(32'h5, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, r, st, m);
        checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", r); end
        access(32'h4, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, r, st, m);
        checks++; if (r !== 32'hFFFF8000) begin errors++; $display("FAIL lh_signed got %h want ffff8000", r); end
        access(32'h6, 32'hBBBBA5C3, 1'b0, 1'b1, 2'b01, 1'b0, r, st, m);
        access(32'h4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'hA5C38000) begin errors++; $display("FAIL sh_upper got %h want a5c38000", r); end
    endtask

    task automatic test_misaligned();
        logic [31:0] r; int st; logic m;
        sel = 1;
        access(32'h7, 32'h0000AAAA, 1'b0, 1'b1, 2'b01, 1'b0, r, st, m);
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_sh_flag got %b want 1", m); end
        checks++; if (st !== 0) begin errors++; $display("FAIL mis_sh_stall got %0d want 0", st); end
        access(32'h2, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_lw_flag got %b want 1", m); end
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mis_lw_rd got %h want 0", r); end
        access(32'h4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'hA5C38000) begin errors++; $display("FAIL mis_mem_unchanged got %h want a5c38000", r); end
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL aligned_flag got %b want 0", m); end
    endtask

    task automatic test_abort();
        logic [31:0] r; int st; logic m;
        sel = 2;
        access(32'h20, 32'h11111111, 1'b0, 1'b1, 2'b10, 1'b0, r, st, m);
        checks++; if (st !== 3) begin errors++; $display("FAIL ws3_store_stall got %0d want 3", st); end
        @(negedge clk);
        a = 32'h20; wd = 32'h22222222; we = 1'b1; re = 1'b0; size = 2'b10;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL abort_stall got %b want 1", stall_o); end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL abort_drop_stall got %b want 0", stall_o); end
        access(32'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL abort_mem got %h want 11111111", r); end
        checks++; if (st !== 3) begin errors++; $display("FAIL abort_idle_stall got %0d want 3", st); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r; int st; logic m;
        sel = 2;
        @(negedge clk);
        a = 32'h24; wd = 32'h33333333; we = 1'b1; re = 1'b0; size = 2'b10;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstwait_stall got %b want 0", stall_o); end
        checks++; if (tv2 !== 16'h0) begin errors++; $display("FAIL rstwait_tv got %h want 0", tv2); end
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(32'h24, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rstwait_nowrite got %h want 0", r); end
        access(32'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL rstwait_cleared got %h want 0", r); end
    endtask

    task automatic test_wrap();
        logic [31:0] r; int st; logic m;
        sel = 1;
        access(32'h400, 32'hCAFEF00D, 1'b0, 1'b1, 2'b10, 1'b0, r, st, m);
        checks++; if (tv_o !== 16'hF00D) begin errors++; $display("FAIL wrap_tv got %h want f00d", tv_o); end
        access(32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, r, st, m);
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_load got %h want cafef00d", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int st; logic m;
        sel = 0;
        access(32'h40, 32'h000000AB, 1'b0, 1'b1, 2'b00, 1'b0, r, st, m);
        access(32'h41, 32'h000000CD, 1'b0, 1'b1, 2'b00, 1'b0, r, st, m);
        access(32'h40, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, r, st, m);
        checks++; if (r !== 32'h0000CDAB) begin errors++; $display("FAIL b2b_half got %h want 0000cdab", r); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; re = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; size = 2'b10; sgn = 1'b0; sel = 0;
        #12;
        test_reset();
        test_ws0();
        test_ws2();
        test_subword();
        test_misaligned();
        test_abort();
        test_reset_mid_wait();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
